i2c_cfg_sequencer: RTL and testbench

//  Walks a fixed command table and drives the I2C master through it: register writes,

---
 rtl/i2c_cfg_pkg.sv | 35 +++
 rtl/i2c_cfg_sequencer_if.sv | 22 ++
 rtl/i2c_cfg_rom.sv | 25 ++
 rtl/i2c_cfg_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types for the I2C configuration sequencer: table entry layout,
// opcode and error-code encodings.
package i2c_cfg_pkg;

  typedef enum logic [1:0] {
    OpWrite   = 2'b00,
    OpReadChk = 2'b01,
    OpDelay   = 2'b10,
    OpEnd     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'b00,
    ErrNak      = 2'b01,
    ErrMismatch = 2'b10,
    ErrTimeout  = 2'b11
  } err_e;

  localparam int unsigned EntryWidth = 17;

  typedef struct packed {
    op_e        op;
    logic [6:0] addr;
    logic [7:0] data;
  } entry_t;

  function automatic entry_t make_entry(op_e op, logic [6:0] addr, logic [7:0] data);
    entry_t e;
    e.op   = op;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Command port between the sequencer and the I2C master.
// The master modport is the sequencer side (it issues commands);
// the slave modport is the I2C master engine that executes them.
interface i2c_cfg_sequencer_if ();
  logic       m_start;
  logic [6:0] m_slave_addr;
  logic       m_rw;
  logic [7:0] m_tx_data;
  logic [7:0] m_rx_data;
  logic       m_ack_error;
  logic       m_busy;

  modport master (
    output m_start, m_slave_addr, m_rw, m_tx_data,
    input  m_rx_data, m_ack_error, m_busy
  );

  modport slave (
    input  m_start, m_slave_addr, m_rw, m_tx_data,
    output m_rx_data, m_ack_error, m_busy
  );
endinterface

// File: rtl/i2c_cfg_rom.sv
// Fixed initialisation table: codec register writes, a read-back check,
// a settle delay and the END marker. Unlisted slots read as END.
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned IW = 4
) (
  input  logic [IW-1:0]         index,
  output logic [EntryWidth-1:0] entry
);

  // Combinational index -> entry lookup
  always_comb begin
    entry = make_entry(OpEnd, 7'h00, 8'h00);
    case (32'(index))
      0:       entry = make_entry(OpWrite,   7'h1A, 8'h05);
      1:       entry = make_entry(OpWrite,   7'h1A, 8'h07);
      2:       entry = make_entry(OpReadChk, 7'h1A, 8'h5A);
      3:       entry = make_entry(OpDelay,   7'h00, 8'h03);
      4:       entry = make_entry(OpWrite,   7'h1A, 8'h09);
      default: ;
    endcase
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the command table in i2c_cfg_rom and drives the I2C master through it,
// with per-entry retry, a transfer watchdog, timed delays and a graceful abort.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = 16,
  parameter int unsigned DELAY_UNIT   = 1000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned XFER_TIMEOUT = 65535,
  parameter int unsigned GAP_CYCLES   = 8,
  localparam int unsigned IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 abort,
  output logic                 running,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [IW-1:0]        cur_index,
  i2c_cfg_sequencer_if.master  m
);

  localparam int unsigned TW = $clog2(XFER_TIMEOUT + 1);
  localparam int unsigned DW = $clog2(255 * DELAY_UNIT + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IW-1:0] LastIndex = IW'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StIssue, StWaitBusy, StWaitDone, StCheck, StGap, StDelay, StDone, StFail
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   delay_q;
  logic [GW-1:0]   gap_q;
  logic [RW-1:0]   retry_q;
  logic            go_q;
  logic            abort_q;
  logic            past_end_q;  // index already advanced past the last slot
  logic            nak_q;
  logic            mis_q;

  logic [EntryWidth-1:0] rom_word;
  entry_t                entry;

  assign entry = entry_t'(rom_word);

  i2c_cfg_rom #(
    .IW (IW)
  ) u_rom (
    .index (cur_index),
    .entry (rom_word)
  );

  // Sequencer FSM with registered status and master command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      delay_q        <= '0;
      gap_q          <= '0;
      retry_q        <= '0;
      go_q           <= 1'b0;
      abort_q        <= 1'b0;
      past_end_q     <= 1'b0;
      nak_q          <= 1'b0;
      mis_q          <= 1'b0;
      running        <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= ErrNone;
      cur_index      <= '0;
      m.m_start      <= 1'b0;
      m.m_slave_addr <= '0;
      m.m_rw         <= 1'b0;
      m.m_tx_data    <= '0;
    end else begin
      go_q      <= go;
      m.m_start <= 1'b0;
      // Abort is only remembered while a sequence is active
      if (abort && running) abort_q <= 1'b1;

      case (state_q)
        StIdle, StDone, StFail: begin
          if (go && !go_q) begin
            state_q    <= StFetch;
            running    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ErrNone;
            cur_index  <= '0;
            retry_q    <= '0;
            abort_q    <= 1'b0;
            past_end_q <= 1'b0;
          end
        end
        StFetch: begin
          if (abort_q || abort) begin
            state_q <= StIdle;
            running <= 1'b0;
          end else if (past_end_q || entry.op == OpEnd) begin
            state_q <= StDone;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (entry.op == OpDelay) begin
            state_q <= StDelay;
            // Zero delay still spends one cycle in StDelay
            delay_q <= (entry.data == 8'd0) ? '0 : DW'(32'(entry.data) * DELAY_UNIT - 32'd1);
          end else begin
            state_q        <= StIssue;
            m.m_start      <= 1'b1;
            m.m_slave_addr <= entry.addr;
            m.m_rw         <= (entry.op == OpReadChk);
            m.m_tx_data    <= entry.data;
            timer_q        <= '0;
          end
        end
        StIssue: state_q <= StWaitBusy;
        StWaitBusy, StWaitDone: begin
          if (state_q == StWaitDone && !m.m_busy) begin
            state_q <= StCheck;
            nak_q   <= m.m_ack_error;
            mis_q   <= m.m_rw && (m.m_rx_data != m.m_tx_data);
          end else if (timer_q == TW'(XFER_TIMEOUT - 1)) begin
            state_q  <= StFail;
            running  <= 1'b0;
            error    <= 1'b1;
            err_code <= ErrTimeout;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (state_q == StWaitBusy && m.m_busy) state_q <= StWaitDone;
          end
        end
        StCheck: begin
          if (!nak_q && !mis_q) begin
            retry_q <= '0;
            state_q <= StGap;
            gap_q   <= GW'(GAP_CYCLES - 1);
            if (cur_index == LastIndex) past_end_q <= 1'b1;
            else                        cur_index  <= cur_index + 1'b1;
          end else if (retry_q != RW'(MAX_RETRY)) begin
            retry_q <= retry_q + 1'b1;
            state_q <= StGap;
            gap_q   <= GW'(GAP_CYCLES - 1);
          end else begin
            state_q  <= StFail;
            running  <= 1'b0;
            error    <= 1'b1;
            err_code <= nak_q ? ErrNak : ErrMismatch;
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            if (abort_q || abort) begin
              state_q <= StIdle;
              running <= 1'b0;
            end else begin
              state_q <= StFetch;
            end
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        StDelay: begin
          if (abort_q || abort) begin
            state_q <= StIdle;
            running <= 1'b0;
          end else if (delay_q == '0) begin
            state_q <= StFetch;
            if (cur_index == LastIndex) past_end_q <= 1'b1;
            else                        cur_index  <= cur_index + 1'b1;
          end else begin
            delay_q <= delay_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: behavioural I2C master fed from a response plan,
// and a table-walking reference model predicting transfers and final status.
module tb_i2c_cfg_sequencer;
  import i2c_cfg_pkg::*;

  localparam int unsigned NUM_ENTRIES  = 16;
  localparam int unsigned DELAY_UNIT   = 10;
  localparam int unsigned MAX_RETRY    = 3;
  localparam int unsigned XFER_TIMEOUT = 100;
  localparam int unsigned GAP_CYCLES   = 8;
  localparam int          BUSY_LEN     = 20;
  localparam int          PLAN_LEN     = 20;

  // Expected table contents: op 0 W, 1 READ_CHK, 2 DELAY, 3 END
  int tbl_op   [6] = '{0, 0, 1, 2, 0, 3};
  int tbl_addr [6] = '{'h1A, 'h1A, 'h1A, 0, 'h1A, 0};
  int tbl_data [6] = '{'h05, 'h07, 'h5A, 3, 'h09, 0};

  typedef struct packed { logic hang; logic nak; logic [7:0] rx; } resp_t;
  typedef struct packed { logic [6:0] addr; logic rw; logic [7:0] data; } xact_t;

  logic       clk = 1'b0;
  logic       rst_n, go, abort;
  logic       running, done, error;
  logic [1:0] err_code;
  logic [3:0] cur_index;

  i2c_cfg_sequencer_if bus ();

  i2c_cfg_sequencer #(
    .NUM_ENTRIES  (NUM_ENTRIES),
    .DELAY_UNIT   (DELAY_UNIT),
    .MAX_RETRY    (MAX_RETRY),
    .XFER_TIMEOUT (XFER_TIMEOUT),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .abort     (abort),
    .running   (running),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .cur_index (cur_index),
    .m         (bus)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  resp_t plan[$], mplan[$];
  xact_t exp_q[$], obs_q[$];
  int    start_cyc[$], fall_cyc[$];
  int    exp_dx, exp_idx;
  bit    exp_done, exp_err;
  int    exp_code;
  resp_t pass_r = '{hang: 1'b0, nak: 1'b0, rx: 8'h5A};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural I2C master: busy for BUSY_LEN cycles per start, result at busy fall
  initial begin
    resp_t cur;
    int    busy_cnt;
    busy_cnt        = 0;
    cur             = pass_r;
    bus.m_busy      = 1'b0;
    bus.m_ack_error = 1'b0;
    bus.m_rx_data   = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt        = 0;
        bus.m_busy      = 1'b0;
        bus.m_ack_error = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.m_busy      = 1'b0;
          bus.m_ack_error = cur.nak;
          bus.m_rx_data   = cur.rx;
          fall_cyc.push_back(cyc);
        end
      end else if (bus.m_start === 1'b1) begin
        obs_q.push_back('{addr: bus.m_slave_addr, rw: bus.m_rw, data: bus.m_tx_data});
        start_cyc.push_back(cyc);
        if (mplan.size() > 0) cur = mplan.pop_front();
        else                  cur = pass_r;
        if (!cur.hang) begin
          bus.m_busy = 1'b1;
          busy_cnt   = BUSY_LEN;
        end
      end
    end
  end

  // Reference: walk the table, consuming one planned response per attempt
  task automatic model_run();
    int    k, idx, attempt;
    bit    fin, adv, after_delay;
    resp_t r;
    xact_t x;
    k = 0; idx = 0; fin = 0; after_delay = 0;
    exp_q.delete();
    exp_dx = -1; exp_done = 0; exp_err = 0; exp_code = 0; exp_idx = 0;
    while (!fin) begin
      if (idx > 5 || tbl_op[idx] == 3) begin
        fin = 1; exp_done = 1; exp_idx = idx;
      end else if (tbl_op[idx] == 2) begin
        after_delay = 1;
        idx++;
      end else begin
        attempt = 0; adv = 0;
        while (!adv && !fin) begin
          r = plan[k]; k++;
          x.addr = 7'(tbl_addr[idx]);
          x.rw   = (tbl_op[idx] == 1);
          x.data = 8'(tbl_data[idx]);
          exp_q.push_back(x);
          if (after_delay) begin exp_dx = exp_q.size() - 1; after_delay = 0; end
          if (r.hang) begin
            fin = 1; exp_err = 1; exp_code = 3; exp_idx = idx;
          end else if (!r.nak && (tbl_op[idx] == 0 || r.rx == 8'(tbl_data[idx]))) begin
            adv = 1; idx++;
          end else if (attempt == int'(MAX_RETRY)) begin
            fin = 1; exp_err = 1; exp_code = r.nak ? 1 : 2; exp_idx = idx;
          end else begin
            attempt++;
          end
        end
      end
    end
  endtask

  task automatic start_go(input bit hold);
    mplan = plan;
    obs_q.delete(); start_cyc.delete(); fall_cyc.delete();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    if (!hold) go = 1'b0;
    check("go_running", running, 1'b1);
    check("go_clears_status", {done, error, err_code}, 4'b0000);
  endtask

  task automatic wait_idle(input int limit, output int end_c);
    bit seen = 0;
    end_c = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (!running) begin seen = 1; end_c = cyc; end
    end
    check("sequence_terminates", seen, 1'b1);
  endtask

  task automatic run_seq(input bit hold);
    int end_c, norm;
    while (plan.size() < PLAN_LEN) plan.push_back(pass_r);
    model_run();
    start_go(hold);
    wait_idle(4000, end_c);
    check("done", done, exp_done);
    check("error", error, exp_err);
    check("err_code", err_code, exp_code);
    check("cur_index", cur_index, exp_idx);
    check("xact_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("xact%0d", i), obs_q[i], exp_q[i]);
    for (int i = 1; i < start_cyc.size() && i <= fall_cyc.size(); i++)
      check($sformatf("gap_idle%0d", i), (start_cyc[i] - fall_cyc[i-1]) >= int'(GAP_CYCLES), 1);
    if (exp_dx > 1 && start_cyc.size() > exp_dx) begin
      // Delay path costs data*DELAY_UNIT plus one fetch for the delay entry itself
      norm = start_cyc[1] - start_cyc[0];
      check("delay_cycles", start_cyc[exp_dx] - start_cyc[exp_dx-1] - norm, 3 * DELAY_UNIT + 1);
    end
    if (exp_code == 3 && start_cyc.size() > 0)
      check("timeout_latency",
            (end_c - start_cyc[$] >= int'(XFER_TIMEOUT)) &&
            (end_c - start_cyc[$] <= int'(XFER_TIMEOUT) + 2), 1);
  endtask

  initial begin
    int end_c, n;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {running, done, error, err_code, cur_index}, 0);
    check("reset_no_start", bus.m_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;  // ignored while idle
    @(negedge clk);
    abort = 1'b0;

    // All writes/reads acknowledged
    plan.delete();
    run_seq(0);

    // Entry 1 NAKs every time: four attempts then NAK error
    plan.delete();
    plan.push_back(pass_r);
    repeat (4) plan.push_back('{hang: 1'b0, nak: 1'b1, rx: 8'h00});
    run_seq(0);

    // Read-back returns wrong data once, then the expected value
    plan.delete();
    plan.push_back(pass_r); plan.push_back(pass_r);
    plan.push_back('{hang: 1'b0, nak: 1'b0, rx: 8'h00});
    plan.push_back(pass_r);
    run_seq(0);

    // Master never goes busy: watchdog, no retry
    plan.delete();
    plan.push_back('{hang: 1'b1, nak: 1'b0, rx: 8'h00});
    run_seq(0);

    // go held high after completion must not restart
    plan.delete();
    run_seq(1);
    n = obs_q.size();
    repeat (40) @(negedge clk);
    check("hold_go_idle", running, 1'b0);
    check("hold_go_no_xact", obs_q.size(), n);
    go = 1'b0;

    // Abort mid-transfer: transfer completes, then stop without done/error
    plan.delete();
    while (plan.size() < PLAN_LEN) plan.push_back(pass_r);
    start_go(0);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(500, end_c);
    check("abort_xacts", obs_q.size(), 1);
    check("abort_xfer_completed", fall_cyc.size(), 1);
    if (fall_cyc.size() > 0) check("abort_after_xfer", end_c > fall_cyc[0], 1);
    check("abort_status", {done, error, err_code}, 4'b0000);
    check("abort_index", cur_index, 1);

    // Reset in the middle of a transfer
    start_go(0);
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {running, done, error, err_code, cur_index}, 0);
    check("midreset_cmd", {bus.m_start, bus.m_slave_addr, bus.m_rw, bus.m_tx_data}, 0);
    repeat (3) @(negedge clk);
    check("midreset_no_start", bus.m_start, 1'b0);
    rst_n = 1'b1;
    mplan.delete();
    repeat (2) @(negedge clk);

    // Randomised master responses
    for (int t = 0; t < 20; t++) begin
      plan.delete();
      for (int i = 0; i < PLAN_LEN; i++) begin
        resp_t r;
        int    sel;
        sel    = $urandom_range(0, 15);
        r.hang = (sel == 0);
        r.nak  = (sel >= 1 && sel <= 3);
        r.rx   = ($urandom_range(0, 1) == 1) ? 8'h5A : 8'($urandom);
        plan.push_back(r);
      end
      run_seq(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
